// File: rtl/gate_chk_pkg.sv
// Shared types and helpers for the gate self-test sequencer.
package gate_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } gate_chk_state_e;

   localparam int GATE_CHK_NUM_VECS = 4;

   // Golden response of the gate block: {AND, OR, NOT a}.
   function automatic logic [2:0] gate_expect(input logic a, input logic b);
      return {a & b, a | b, ~a};
   endfunction

endpackage

// File: rtl/gate_chk_golden.sv
// Combinational golden model of the AND/OR/NOT gate block.
module gate_golden
   import gate_chk_pkg::*;
(
   input  logic       a,
   input  logic       b,
   output logic [2:0] expected
);

   assign expected = gate_expect(a, b);

endmodule

// File: rtl/gate_truth_checker.sv
// Self-test sequencer for the AND/OR/NOT gate block: sweeps {a,b} through
// 00,01,10,11 (NUM_PASSES times), checks {x,y,z} against the golden model
// and reports pass/fail plus a saturating error count.
// Optional macro GATE_CHK_FIRST_ERR_EN builds the first-error capture
// registers; without it first_err_vec/first_err_obs are tied to 0.
module gate_truth_checker
   import gate_chk_pkg::*;
#(
   parameter int unsigned NUM_PASSES    = 1,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 a,
   output logic                 b,
   input  logic                 x,
   input  logic                 y,
   input  logic                 z,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [1:0]           first_err_vec,
   output logic [2:0]           first_err_obs
);

   localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
   localparam int unsigned WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LOAD =
      (SETTLE_CYCLES > 0) ? WAIT_W'(SETTLE_CYCLES - 1) : '0;
   localparam logic [1:0] LAST_VEC = 2'(GATE_CHK_NUM_VECS - 1);

   gate_chk_state_e       state;
   logic [PASS_W-1:0]     pass_idx;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [2:0]            expected;
   logic                  mismatch;
   logic [ERR_CNT_W-1:0]  err_next;

   // The registered {a,b} doubles as the vector index within a sweep.
   gate_golden u_golden (
      .a        (a),
      .b        (b),
      .expected (expected)
   );

   // Compare the gate response and form the saturating error count.
   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      mismatch = ({x, y, z} != expected);
      err_next = err_cnt;
      if (mismatch && (err_cnt != '1)) begin
         err_next = err_cnt + 1'b1;
      end
   end

   // Sequencer FSM with registered stimulus and status outputs.
   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         a        <= 1'b0;
         b        <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= '0;
         pass_idx <= '0;
         wait_cnt <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_APPLY;
                  {a, b}   <= 2'b00;
                  pass_idx <= '0;
                  err_cnt  <= '0;
                  pass     <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            ST_APPLY: begin
               if (SETTLE_CYCLES == 0) begin
                  state <= ST_CHECK;
               end else begin
                  wait_cnt <= WAIT_LOAD;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == '0) begin
                  state <= ST_CHECK;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_CHECK: begin
               err_cnt <= err_next;
               if ({a, b} != LAST_VEC) begin
                  {a, b} <= {a, b} + 2'd1;
                  state  <= ST_APPLY;
               end else if (pass_idx != LAST_PASS) begin
                  {a, b}   <= 2'b00;
                  pass_idx <= pass_idx + 1'b1;
                  state    <= ST_APPLY;
               end else begin
                  // {a,b} is already 2'b11 here and is held through DONE and IDLE.
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef GATE_CHK_FIRST_ERR_EN
   logic [1:0] first_vec_q;
   logic [2:0] first_obs_q;

   // Capture the stimulus and response of the first failing check of a run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_vec_q <= '0;
         first_obs_q <= '0;
      end else if ((state == ST_IDLE) && start) begin
         first_vec_q <= '0;
         first_obs_q <= '0;
      end else if ((state == ST_CHECK) && mismatch && (err_cnt == '0)) begin
         first_vec_q <= {a, b};
         first_obs_q <= {x, y, z};
      end
   end

   assign first_err_vec = first_vec_q;
   assign first_err_obs = first_obs_q;
`else
   assign first_err_vec = '0;
   assign first_err_obs = '0;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Self-checking bench for gate_truth_checker: four configurations driven by
// a behavioural gate block with selectable faults, scoreboarded per cycle.
module tb_gate_truth_checker;

   // fault codes: 0 = correct gate, 1 = x stuck-at-0, 2 = z wired to a
   function automatic int np_of(input int i);
      return (i == 1 || i == 2) ? 3 : 1;
   endfunction
   function automatic int sc_of(input int i);
      return (i >= 2) ? 0 : 1;
   endfunction
   function automatic int ew_of(input int i);
      return (i == 2) ? 3 : 8;
   endfunction

   function automatic logic [2:0] gate_model(input logic [1:0] fault, input logic a, input logic b);
      logic [2:0] r;
      r = {a & b, a | b, !a};
      if (fault == 2'd1) r[2] = 1'b0;
      if (fault == 2'd2) r[0] = a;
      return r;
   endfunction

   function automatic logic [2:0] ref_gate(input logic a, input logic b);
      return {(a && b), (a || b), (a == 1'b0)};
   endfunction

`ifdef GATE_CHK_FIRST_ERR_EN
   localparam bit FE_EN = 1'b1;
`else
   localparam bit FE_EN = 1'b0;
`endif

   typedef struct packed {
      logic       busy;
      logic       done;
      logic [1:0] ab;
   } cyc_t;

   typedef struct packed {
      logic       pass;
      logic [7:0] err;
      logic [1:0] fev;
      logic [2:0] feo;
   } res_t;

   logic       clk;
   logic       rst_n;
   logic       start_v [4];
   logic [1:0] fault_v [4];
   logic       a_v [4];
   logic       b_v [4];
   logic       x_v [4];
   logic       y_v [4];
   logic       z_v [4];
   logic       busy_v [4];
   logic       done_v [4];
   logic       pass_v [4];
   logic [7:0] err_v [4];
   logic [1:0] fev_v [4];
   logic [2:0] feo_v [4];

   cyc_t cyc_q[$];
   res_t res_q[$];
   int   checks   = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int unsigned EW = ew_of(g);
      logic [EW-1:0] ec;
      logic [2:0]    gout;

      gate_truth_checker #(
         .NUM_PASSES    (np_of(g)),
         .SETTLE_CYCLES (sc_of(g)),
         .ERR_CNT_W     (EW)
      ) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .start         (start_v[g]),
         .a             (a_v[g]),
         .b             (b_v[g]),
         .x             (x_v[g]),
         .y             (y_v[g]),
         .z             (z_v[g]),
         .busy          (busy_v[g]),
         .done          (done_v[g]),
         .pass          (pass_v[g]),
         .err_cnt       (ec),
         .first_err_vec (fev_v[g]),
         .first_err_obs (feo_v[g])
      );

      assign err_v[g] = 8'(ec);
      assign gout     = gate_model(fault_v[g], a_v[g], b_v[g]);
      assign x_v[g]   = gout[2];
      assign y_v[g]   = gout[1];
      assign z_v[g]   = gout[0];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input int i, input string tag);
      check($sformatf("%s u%0d a", tag, i), 32'(a_v[i]), 0);
      check($sformatf("%s u%0d b", tag, i), 32'(b_v[i]), 0);
      check($sformatf("%s u%0d busy", tag, i), 32'(busy_v[i]), 0);
      check($sformatf("%s u%0d done", tag, i), 32'(done_v[i]), 0);
      check($sformatf("%s u%0d pass", tag, i), 32'(pass_v[i]), 0);
      check($sformatf("%s u%0d err", tag, i), 32'(err_v[i]), 0);
      check($sformatf("%s u%0d fev", tag, i), 32'(fev_v[i]), 0);
      check($sformatf("%s u%0d feo", tag, i), 32'(feo_v[i]), 0);
   endtask

   // Pops one expected cycle per negedge and compares busy/done/{a,b}.
   task automatic drain_cycles(input int i, input string tag);
      cyc_t c;
      int   k;
      k = 1;
      while (cyc_q.size() > 0) begin
         c = cyc_q.pop_front();
         check($sformatf("%s u%0d c%0d busy", tag, i, k), 32'(busy_v[i]), 32'(c.busy));
         check($sformatf("%s u%0d c%0d done", tag, i, k), 32'(done_v[i]), 32'(c.done));
         check($sformatf("%s u%0d c%0d ab", tag, i, k), 32'({a_v[i], b_v[i]}), 32'(c.ab));
         k++;
         if (cyc_q.size() > 0) @(negedge clk);
      end
   endtask

   // Single run from a start pulse; call at a negedge with the DUT idle.
   task automatic run_sweep(input int i, input string tag);
      int         errs;
      int         sat;
      bit         seen;
      logic [1:0] vec;
      logic [2:0] obs;
      res_t       r;
      errs = 0;
      seen = 1'b0;
      r    = '0;
      for (int p = 0; p < np_of(i); p++) begin
         for (int v = 0; v < 4; v++) begin
            vec = 2'(v);
            for (int s = 0; s < 2 + sc_of(i); s++) cyc_q.push_back('{busy: 1'b1, done: 1'b0, ab: vec});
            obs = gate_model(fault_v[i], vec[1], vec[0]);
            if (obs != ref_gate(vec[1], vec[0])) begin
               if (!seen && FE_EN) begin
                  r.fev = vec;
                  r.feo = obs;
               end
               seen = 1'b1;
               errs++;
            end
         end
      end
      cyc_q.push_back('{busy: 1'b0, done: 1'b1, ab: 2'b11});
      sat    = (1 << ew_of(i)) - 1;
      r.err  = 8'((errs > sat) ? sat : errs);
      r.pass = (errs == 0);
      res_q.push_back(r);

      start_v[i] = 1'b1;
      @(negedge clk);
      start_v[i] = 1'b0;
      drain_cycles(i, tag);
      r = res_q.pop_front();
      check($sformatf("%s u%0d pass", tag, i), 32'(pass_v[i]), 32'(r.pass));
      check($sformatf("%s u%0d err_cnt", tag, i), 32'(err_v[i]), 32'(r.err));
      check($sformatf("%s u%0d first_err_vec", tag, i), 32'(fev_v[i]), 32'(r.fev));
      check($sformatf("%s u%0d first_err_obs", tag, i), 32'(feo_v[i]), 32'(r.feo));
   endtask

   // start held high: every run is followed by one DONE and one IDLE cycle.
   task automatic run_back_to_back(input int i, input int runs);
      for (int r = 0; r < runs; r++) begin
         for (int p = 0; p < np_of(i); p++)
            for (int v = 0; v < 4; v++)
               for (int s = 0; s < 2 + sc_of(i); s++)
                  cyc_q.push_back('{busy: 1'b1, done: 1'b0, ab: 2'(v)});
         cyc_q.push_back('{busy: 1'b0, done: 1'b1, ab: 2'b11});
         cyc_q.push_back('{busy: 1'b0, done: 1'b0, ab: 2'b11});
      end
      start_v[i] = 1'b1;
      @(negedge clk);
      drain_cycles(i, "b2b");
      start_v[i] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         start_v[i] = 1'b0;
         fault_v[i] = 2'd0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) check_zero(i, "por");
      rst_n = 1'b1;
      @(negedge clk);

      // Correct gate, default parameters.
      run_sweep(0, "good");
      @(negedge clk);
      check("idle hold ab", 32'({a_v[0], b_v[0]}), 32'h3);
      check("idle hold pass", 32'(pass_v[0]), 32'h1);

      // Asynchronous reset mid-cycle, checked before the next clock edge.
      #2 rst_n = 1'b0;
      #1 check_zero(0, "async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Stuck-at-0 on x: one error at vector 11.
      fault_v[0] = 2'd1;
      run_sweep(0, "x_sa0");
      @(negedge clk);

      // z wired to a over three passes, with wide and narrow counters.
      fault_v[1] = 2'd2;
      run_sweep(1, "z_eq_a");
      @(negedge clk);
      fault_v[2] = 2'd2;
      run_sweep(2, "z_sat");
      @(negedge clk);

      // Reset during WAIT of vector 01, then a clean restart.
      fault_v[0] = 2'd2;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      check("midrun busy", 32'(busy_v[0]), 32'h1);
      check("midrun ab", 32'({a_v[0], b_v[0]}), 32'h1);
      check("midrun err_cnt", 32'(err_v[0]), 32'h1);
      #2 rst_n = 1'b0;
      #1 check_zero(0, "midrun_rst");
      @(negedge clk);
      rst_n = 1'b1;
      fault_v[0] = 2'd0;
      @(negedge clk);
      run_sweep(0, "restart");
      @(negedge clk);

      // start held high, SETTLE_CYCLES=0: back-to-back 8-cycle runs.
      run_back_to_back(3, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
